// File: rtl/stop_it_pkg.sv
// stop_it_pkg: shared state encoding and widths for the stop-it game controller.
//   state_e   : FSM states, also used as the display mux select
//   RandWidth : width of the LFSR value, target and tick counter
package stop_it_pkg;
    typedef enum logic [2:0] {IDLE, COUNTING, CORRECT, WRONG, WON, LOST} state_e;
    localparam int RandWidth = 5;
endpackage

// File: rtl/stop_it_flash_timer.sv
// stop_it_flash_timer: tick-qualified down-counter that times the result flash.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : start a flash period (FlashTicks ticks, flash_o high)
//   tick_i        : timebase pulse; each one toggles flash_o and counts down
//   done_o        : high on the tick that ends the period
//   flash_o       : blink enable, forced low once the period ends
module stop_it_flash_timer #(
    parameter int FlashTicks = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic tick_i,
    output logic done_o,
    output logic flash_o
);
    localparam int CW = $clog2(FlashTicks + 1);

    logic [CW-1:0] cnt_q;

    assign done_o = tick_i && (cnt_q == CW'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            flash_o <= 1'b0;
        end else if (load_i) begin
            cnt_q   <= CW'(FlashTicks);
            flash_o <= 1'b1;
        end else if (tick_i && cnt_q != '0) begin
            cnt_q   <= cnt_q - 1'b1;
            flash_o <= done_o ? 1'b0 : ~flash_o;
        end
    end
endmodule

// File: rtl/stop_it_ctrl.sv
// stop_it_ctrl: stop-it game controller between the LFSR/timebase and display/LEDs.
//   clk_i, rst_ni : clock, async active-low reset
//   tick_i        : slow game-rate pulse
//   go_i, stop_i  : debounced button pulses
//   rand_i        : LFSR value, latched as target on start
//   lfsr_next_o   : keeps the LFSR advancing while idle
//   target_o, count_o, score_o, state_o, flash_o, lives_o : game status
// Optional lives support is enabled by defining STOP_IT_LIVES_EN; otherwise
// lives_o is tied to 0 and LOST is unreachable.
module stop_it_ctrl
    import stop_it_pkg::*;
#(
    parameter int ScoreWidth = 4,
    parameter int WinScore   = 15,
    parameter int FlashTicks = 4,
    parameter int Lives      = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  tick_i,
    input  logic                  go_i,
    input  logic                  stop_i,
    input  logic [RandWidth-1:0]  rand_i,
    output logic                  lfsr_next_o,
    output logic [RandWidth-1:0]  target_o,
    output logic [RandWidth-1:0]  count_o,
    output logic [ScoreWidth-1:0] score_o,
    output state_e                state_o,
    output logic                  flash_o,
    output logic [1:0]            lives_o
);
    state_e                state_q;
    logic [RandWidth-1:0]  target_q, count_q;
    logic [ScoreWidth-1:0] score_q;
    logic                  flash_load, flash_done;

    // The stop is judged in the same cycle it arrives, so the flash period starts with it.
    assign flash_load  = (state_q == COUNTING) && stop_i;
    assign lfsr_next_o = (state_q == IDLE);
    assign target_o    = target_q;
    assign count_o     = count_q;
    assign score_o     = score_q;
    assign state_o     = state_q;

`ifdef STOP_IT_LIVES_EN
    logic [1:0] lives_q;
    assign lives_o = lives_q;
`else
    logic unused_lives;
    assign lives_o      = 2'b0;
    assign unused_lives = |Lives;
`endif

    stop_it_flash_timer #(.FlashTicks(FlashTicks)) u_flash (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (flash_load),
        .tick_i  (tick_i),
        .done_o  (flash_done),
        .flash_o (flash_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            target_q <= '0;
            count_q  <= '0;
            score_q  <= '0;
`ifdef STOP_IT_LIVES_EN
            lives_q  <= 2'(Lives);
`endif
        end else begin
            case (state_q)
                IDLE: if (go_i) begin
                    target_q <= rand_i;
                    count_q  <= '0;
                    state_q  <= COUNTING;
                end
                // Stop takes priority over a same-cycle tick, which is dropped.
                COUNTING: if (stop_i) begin
                    if (count_q == target_q) begin
                        state_q <= CORRECT;
                        if (score_q != '1) score_q <= score_q + 1'b1;
                    end else begin
                        state_q <= WRONG;
`ifdef STOP_IT_LIVES_EN
                        lives_q <= lives_q - 1'b1;
`endif
                    end
                end else if (tick_i) begin
                    count_q <= count_q + 1'b1;
                end
                CORRECT: if (flash_done) state_q <= (score_q == ScoreWidth'(WinScore)) ? WON : IDLE;
`ifdef STOP_IT_LIVES_EN
                WRONG: if (flash_done) state_q <= (lives_q == 2'd0) ? LOST : IDLE;
`else
                WRONG: if (flash_done) state_q <= IDLE;
`endif
                WON, LOST: if (go_i) begin
                    state_q  <= IDLE;
                    score_q  <= '0;
                    count_q  <= '0;
                    target_q <= '0;
`ifdef STOP_IT_LIVES_EN
                    lives_q  <= 2'(Lives);
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
